byte_mem_ctrl: RTL and testbench

Controller that shares one single-port, byte-wide synchronous RAM (1-cycle registered read latency) between the MCU instruction-fetch port and the load/store data port. It serialises 8/16/32-bit RV32I accesses into per-byte RAM cycles, with the following behaviour:
- little-endian byte order;
- sign- or zero-extension on loads;
- misaligned or illegal-size requests rejected without touching the RAM;
- round-robin arbitration when both ports request.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/byte_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_byte_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lsb[0];
      SIZE_W:  return |lsb;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_mem_ctrl.sv
// Arbitrates fetch and load/store ports onto one byte-wide synchronous RAM,
// serialising each access into per-byte RAM cycles.
module byte_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [31:0]           i_rdata_o,
  output logic                  i_ack_o,
  output logic                  i_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic [31:0]           d_rdata_o,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_din_o,
  output logic                  ram_we_o,
  input  logic [7:0]            ram_dout_i
);

  state_t                state, state_nx;
  port_t                 port, last_grant;
  logic [2:0]            cnt, nb;
  logic [ADDR_WIDTH-1:0] base;
  logic [1:0]            size;
  logic                  we, uns, err;
  logic [31:0]           wdata, rbuf, ext;
  logic [1:0]            cap_lane, nxt_lane;

  logic                  grant_any, grant_d, sel_we, sel_err;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_size;

  assign nb       = size_bytes(size);
  assign cap_lane = 2'(cnt - 3'd1);
  assign nxt_lane = 2'(cnt + 3'd1);

  // Data port wins a tie unless it was the one granted last.
  assign grant_any = d_req_i | i_req_i;
  assign grant_d   = d_req_i & (~i_req_i | (last_grant == PORT_I));
  assign sel_addr  = grant_d ? d_addr_i : i_addr_i;
  assign sel_size  = grant_d ? d_size_i : SIZE_W;
  assign sel_we    = grant_d & d_we_i;
  assign sel_err   = misaligned(sel_size, sel_addr[1:0]);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (grant_any) state_nx = sel_err ? DONE : RUN;
      RUN: begin
        if (we && cnt == nb - 3'd1) state_nx = DONE;
        if (!we && cnt == nb)       state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      port       <= PORT_I;
      last_grant <= PORT_I;
      cnt        <= '0;
      base       <= '0;
      size       <= SIZE_B;
      we         <= 1'b0;
      uns        <= 1'b0;
      err        <= 1'b0;
      wdata      <= '0;
      rbuf       <= '0;
      ram_addr_o <= '0;
      ram_din_o  <= '0;
      ram_we_o   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (grant_any) begin
          port  <= grant_d ? PORT_D : PORT_I;
          base  <= sel_addr;
          size  <= sel_size;
          we    <= sel_we;
          uns   <= grant_d ? d_unsigned_i : 1'b1;
          wdata <= grant_d ? d_wdata_i : '0;
          err   <= sel_err;
          cnt   <= '0;
          rbuf  <= '0;
          // RAM port is loaded here so the first byte cycle comes straight out of flops.
          if (!sel_err) begin
            ram_addr_o <= sel_addr;
            ram_we_o   <= sel_we;
            ram_din_o  <= sel_we ? d_wdata_i[7:0] : 8'h00;
          end
        end
        RUN: begin
          cnt <= cnt + 3'd1;
          if (!we && cnt != 3'd0) rbuf[{cap_lane, 3'b000} +: 8] <= ram_dout_i;
          if (cnt + 3'd1 < nb) begin
            ram_addr_o <= base + ADDR_WIDTH'(cnt + 3'd1);
            ram_din_o  <= we ? wdata[{nxt_lane, 3'b000} +: 8] : 8'h00;
          end else begin
            ram_we_o  <= 1'b0;
            ram_din_o <= 8'h00;
          end
        end
        DONE:    last_grant <= port;
        default: ;
      endcase
    end
  end

  always_comb begin
    ext = rbuf;
    case (size)
      SIZE_B:  ext = {{24{rbuf[7] & ~uns}}, rbuf[7:0]};
      SIZE_H:  ext = {{16{rbuf[15] & ~uns}}, rbuf[15:0]};
      default: ext = rbuf;
    endcase
  end

  assign i_ack_o   = (state == DONE) && (port == PORT_I);
  assign d_ack_o   = (state == DONE) && (port == PORT_D);
  assign i_err_o   = i_ack_o & err;
  assign d_err_o   = d_ack_o & err;
  assign i_rdata_o = (i_ack_o && !err) ? rbuf : 32'h0;
  assign d_rdata_o = (d_ack_o && !err) ? ext  : 32'h0;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Scoreboard bench for byte_mem_ctrl with a behavioural byte RAM attached.
module tb_byte_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_uns = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [1:0]    d_size = SIZE_B;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   i_rdata, d_rdata;
  logic          i_ack, i_err, d_ack, d_err;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din, ram_dout;
  logic          ram_we;

  logic [7:0]    mem [0:(1<<AW)-1];

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          err;
    int          cyc;
    bit          chk_data;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   we_seen = 1'b0;

  byte_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_ack_o(i_ack), .i_err_o(i_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_unsigned_i(d_uns),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_ack_o(d_ack), .d_err_o(d_err),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_we) we_seen = 1'b1;

  // Scoreboard: every ack pops the oldest expectation; requester drops its request on ack.
  always @(negedge clk) begin
    exp_t        e;
    bit          ad;
    logic [31:0] ar;
    logic        ae;
    if (d_ack || i_ack) begin
      ad = d_ack;
      ar = ad ? d_rdata : i_rdata;
      ae = ad ? d_err : i_err;
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: port_d=%0b at cycle %0d, required no ack", ad, cyc);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (ad !== e.is_d || cyc !== e.cyc)
          $display("FAIL ack_timing: port_d=%0b cycle=%0d, required port_d=%0b cycle=%0d",
                   ad, cyc, e.is_d, e.cyc);
        else passes++;
        checks++;
        if (ae !== e.err) $display("FAIL ack_err: got %0b, required %0b (cycle %0d)", ae, e.err, cyc);
        else passes++;
        if (e.chk_data) begin
          checks++;
          if (ar !== e.data) $display("FAIL ack_rdata: got %h, required %h (cycle %0d)", ar, e.data, cyc);
          else passes++;
        end
      end
      if (ad) d_req = 1'b0;
      else    i_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_q(output bit to);
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (sbq.size() == 0) begin to = 1'b0; break; end
    end
  endtask

  task automatic d_issue(bit we, logic [1:0] sz, bit uns, logic [AW-1:0] a, logic [31:0] wd);
    d_we = we; d_size = sz; d_uns = uns; d_addr = a; d_wdata = wd; d_req = 1'b1;
  endtask

  task automatic i_issue(logic [AW-1:0] a);
    i_addr = a; i_req = 1'b1;
  endtask

  task automatic d_op(bit we, logic [1:0] sz, bit uns, logic [AW-1:0] a, logic [31:0] wd,
                      logic [31:0] exp_d, bit exp_e, int lat, bit chk);
    bit to;
    tick();
    sbq.push_back('{is_d: 1'b1, data: exp_d, err: exp_e, cyc: cyc + lat, chk_data: chk});
    d_issue(we, sz, uns, a, wd);
    wait_q(to);
    checks++;
    if (to) begin $display("FAIL d_timeout: no ack for addr %h, required ack", a); d_req = 1'b0; sbq.delete(); end
    else passes++;
  endtask

  task automatic i_op(logic [AW-1:0] a, logic [31:0] exp_d, bit exp_e, int lat);
    bit to;
    tick();
    sbq.push_back('{is_d: 1'b0, data: exp_d, err: exp_e, cyc: cyc + lat, chk_data: 1'b1});
    i_issue(a);
    wait_q(to);
    checks++;
    if (to) begin $display("FAIL i_timeout: no ack for addr %h, required ack", a); i_req = 1'b0; sbq.delete(); end
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({i_ack, i_err, d_ack, d_err} !== 4'b0000)
      $display("FAIL reset_acks: got %b, required 0000", {i_ack, i_err, d_ack, d_err});
    else passes++;
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h, required 0", {i_rdata, d_rdata});
    else passes++;
    checks++;
    if ({ram_we, ram_addr, ram_din} !== '0)
      $display("FAIL reset_ram: got we=%b addr=%h din=%h, required 0/0/0", ram_we, ram_addr, ram_din);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_store_load_word();
    logic [31:0] w = 32'h11223344;
    d_op(1'b1, SIZE_W, 1'b0, 12'h010, w, 32'h0, 1'b0, 5, 1'b0);
    d_op(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0, w, 1'b0, 6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[12'h010 + i] !== w[8*i +: 8])
        $display("FAIL word_ram_byte%0d: got %h, required %h", i, mem[12'h010 + i], w[8*i +: 8]);
      else passes++;
    end
  endtask

  task automatic test_load_ext();
    d_op(1'b1, SIZE_B, 1'b0, 12'h020, 32'hDEADBE80, 32'h0, 1'b0, 2, 1'b0);
    d_op(1'b0, SIZE_B, 1'b0, 12'h020, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
    d_op(1'b0, SIZE_B, 1'b1, 12'h020, 32'h0, 32'h00000080, 1'b0, 3, 1'b1);
    d_op(1'b1, SIZE_H, 1'b0, 12'h020, 32'hCAFE8001, 32'h0, 1'b0, 3, 1'b0);
    checks++;
    if ({mem[12'h021], mem[12'h020]} !== 16'h8001)
      $display("FAIL half_ram: got %h, required 8001", {mem[12'h021], mem[12'h020]});
    else passes++;
    d_op(1'b0, SIZE_H, 1'b0, 12'h020, 32'h0, 32'hFFFF8001, 1'b0, 4, 1'b1);
    d_op(1'b0, SIZE_H, 1'b1, 12'h020, 32'h0, 32'h00008001, 1'b0, 4, 1'b1);
  endtask

  task automatic test_misaligned();
    we_seen = 1'b0;
    d_op(1'b0, SIZE_W,   1'b0, 12'h012, 32'h0,        32'h0, 1'b1, 1, 1'b1);
    d_op(1'b1, SIZE_H,   1'b0, 12'h013, 32'h12345678, 32'h0, 1'b1, 1, 1'b1);
    d_op(1'b1, SIZE_ILL, 1'b0, 12'h010, 32'h12345678, 32'h0, 1'b1, 1, 1'b1);
    i_op(12'h002, 32'h0, 1'b1, 1);
    checks++;
    if (we_seen) $display("FAIL err_ram_we: got ram_we high, required never high");
    else passes++;
  endtask

  task automatic test_fetch();
    i_op(12'h010, 32'h11223344, 1'b0, 6);
  endtask

  task automatic test_tie();
    bit to;
    int c;
    tick();
    c = cyc;
    sbq.push_back('{is_d: 1'b1, data: 32'h11223344, err: 1'b0, cyc: c + 6,  chk_data: 1'b1});
    sbq.push_back('{is_d: 1'b0, data: 32'h11223344, err: 1'b0, cyc: c + 13, chk_data: 1'b1});
    d_issue(1'b0, SIZE_W, 1'b0, 12'h010, 32'h0);
    i_issue(12'h010);
    wait_q(to);
    checks++;
    if (to) begin $display("FAIL tie1_timeout: queue left %0d, required 0", sbq.size()); sbq.delete(); end
    else passes++;
    d_op(1'b0, SIZE_B, 1'b1, 12'h010, 32'h0, 32'h00000044, 1'b0, 3, 1'b1);
    tick();
    c = cyc;
    sbq.push_back('{is_d: 1'b0, data: 32'h11223344, err: 1'b0, cyc: c + 6,  chk_data: 1'b1});
    sbq.push_back('{is_d: 1'b1, data: 32'h00000044, err: 1'b0, cyc: c + 10, chk_data: 1'b1});
    d_issue(1'b0, SIZE_B, 1'b1, 12'h010, 32'h0);
    i_issue(12'h010);
    wait_q(to);
    checks++;
    if (to) begin $display("FAIL tie2_timeout: queue left %0d, required 0", sbq.size()); sbq.delete(); end
    else passes++;
    d_req = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_w = 32'hAAAA7788;
    for (int i = 0; i < 4; i++) mem[12'h030 + i] = 8'hAA;
    tick();
    d_issue(1'b1, SIZE_W, 1'b0, 12'h030, 32'h55667788);
    tick();
    tick();
    rst = 1'b1;
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (ram_we !== 1'b0) $display("FAIL midrst_we: got %b, required 0", ram_we);
    else passes++;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[12'h030 + i] !== exp_w[8*i +: 8])
        $display("FAIL midrst_ram_byte%0d: got %h, required %h", i, mem[12'h030 + i], exp_w[8*i +: 8]);
      else passes++;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    test_reset();
    test_store_load_word();
    test_load_ext();
    test_misaligned();
    test_fetch();
    test_tie();
    test_reset_mid();
    test_store_load_word();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
